// File: rtl/vector_pkg.sv
// Shared types and constants for the vexp_seq sequencer.
package vector_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vexp_seq_state_t;

  localparam int VEXP_LAT_DEFAULT = 3;
  localparam fp16_t FP16_ZERO = 16'h0000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vexp_seq_if.sv
// Request/result handshake bundle for vexp_seq; in_mask exists only with VEXP_SEQ_MASK_EN.
// valid/ready: a transfer happens at a rising edge where valid && ready; valid holds until then.
interface vexp_seq_if #(parameter int LANES = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*16-1:0]   in_vec;
`ifdef VEXP_SEQ_MASK_EN
  logic [LANES-1:0]      in_mask;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*16-1:0]   out_vec;

`ifdef VEXP_SEQ_MASK_EN
  modport master (output in_valid, in_vec, in_mask, out_ready,
                  input  in_ready, out_valid, out_vec);
  modport slave  (input  in_valid, in_vec, in_mask, out_ready,
                  output in_ready, out_valid, out_vec);
`else
  modport master (output in_valid, in_vec, out_ready,
                  input  in_ready, out_valid, out_vec);
  modport slave  (input  in_valid, in_vec, out_ready,
                  output in_ready, out_valid, out_vec);
`endif
endinterface

// File: rtl/vexp_tag_pipe.sv
// Capture-tag delay line: {valid, lane index} shifted DEPTH stages, async reset, sync flush.
module vexp_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic             r_valid [DEPTH];
  logic [IDX_W-1:0] r_idx   [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_idx[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_idx[i]   <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/vexp_seq.sv
// Serialises an fp16 vector through a fixed-latency vexp unit and reassembles the results.
// Optional lane masking is enabled by defining VEXP_SEQ_MASK_EN.
module vexp_seq
  import vector_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int VEXP_LAT = VEXP_LAT_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  vexp_seq_if.slave       io,
  output logic            busy,
  output fp16_t           vexp_port_a,
  output logic            vexp_enable,
  input  fp16_t           vexp_out,
  output vexp_seq_state_t o_dbg_state
);

  localparam int IDX_W = idx_width(LANES);
  localparam int DRN_W = idx_width(VEXP_LAT);
  localparam logic [IDX_W-1:0] LAST_LANE  = IDX_W'(LANES - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(VEXP_LAT - 1);

  vexp_seq_state_t  r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_en;
  fp16_t            r_a;
  logic [IDX_W-1:0] r_idx;
  logic [DRN_W-1:0] r_drain;
  logic [LANES-1:0] r_mask;
  fp16_t            r_vec [LANES];
  fp16_t            r_res [LANES];

  logic [LANES-1:0] w_mask_in;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_accept;
  logic             w_tag_valid;
  logic [IDX_W-1:0] w_tag_idx;

`ifdef VEXP_SEQ_MASK_EN
  assign w_mask_in = io.in_mask;
`else
  assign w_mask_in = '1;
`endif

  assign w_next_idx = r_idx + 1'b1;
  assign w_accept   = (r_state == IDLE) && io.in_valid;

  // Tags enter on the edge that ends each issue slot; masked slots carry valid=0.
  vexp_tag_pipe #(.DEPTH(VEXP_LAT), .IDX_W(IDX_W)) u_tags (
    .clk     (CLK),
    .rst     (RST),
    .flush   (w_accept),
    .i_valid ((r_state == ISSUE) && r_en),
    .i_idx   (r_idx),
    .o_valid (w_tag_valid),
    .o_idx   (w_tag_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_en        <= 1'b0;
      r_a         <= FP16_ZERO;
      r_idx       <= '0;
      r_drain     <= '0;
      r_mask      <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_vec[i] <= FP16_ZERO;
        r_res[i] <= FP16_ZERO;
      end
    end else begin
      if (w_tag_valid)
        r_res[w_tag_idx] <= vexp_out;
      case (r_state)
        IDLE: begin
          if (io.in_valid) begin
            for (int i = 0; i < LANES; i++) begin
              r_vec[i] <= io.in_vec[16*i +: 16];
              r_res[i] <= FP16_ZERO;
            end
            r_mask     <= w_mask_in;
            r_idx      <= '0;
            r_en       <= w_mask_in[0];
            r_a        <= w_mask_in[0] ? io.in_vec[15:0] : FP16_ZERO;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_idx == LAST_LANE) begin
            r_en    <= 1'b0;
            r_a     <= FP16_ZERO;
            r_drain <= '0;
            r_state <= DRAIN;
          end else begin
            r_idx <= w_next_idx;
            r_en  <= r_mask[w_next_idx];
            r_a   <= r_mask[w_next_idx] ? r_vec[w_next_idx] : FP16_ZERO;
          end
        end
        DRAIN: begin
          // Last lane's capture lands on the same edge that enters DONE.
          if (r_drain == DRAIN_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign io.out_vec[16*g +: 16] = r_res[g];
  end

  assign io.in_ready  = r_in_ready;
  assign io.out_valid = r_out_valid;
  assign busy         = r_busy;
  assign vexp_enable  = r_en;
  assign vexp_port_a  = r_a;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_vexp_seq.sv
// Bench for vexp_seq (LANES=8, VEXP_LAT=3) with a behavioural fp16 exp unit and reference model.
module tb_vexp_seq;
  import vector_pkg::*;

  localparam int LANES = 8;
  localparam int LAT   = 3;
  localparam int TOTAL = LANES + LAT + 1;
`ifdef VEXP_SEQ_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            busy;
  fp16_t           vexp_port_a;
  logic            vexp_enable;
  fp16_t           vexp_out;
  vexp_seq_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  vexp_seq_if #(.LANES(LANES)) bus ();

  vexp_seq #(.LANES(LANES), .VEXP_LAT(LAT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .io          (bus.slave),
    .busy        (busy),
    .vexp_port_a (vexp_port_a),
    .vexp_enable (vexp_enable),
    .vexp_out    (vexp_out),
    .o_dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  // fp16 helpers (normal numbers and zero only)
  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_fp16(input real r);
    real x;
    int  e;
    int  m;
    x = r;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    m = $rtoi((x - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {1'b0, 5'(e + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] fp_exp(input logic [15:0] h);
    return real_to_fp16($exp(fp16_to_real(h)));
  endfunction

  function automatic logic [15:0] rand_fp16();
    if ($urandom_range(0, 7) == 0) return 16'h0000;
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 17)), 10'($urandom_range(0, 1023))};
  endfunction

  // External vexp unit: fixed LAT-cycle pipeline
  logic [15:0] u_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) u_pipe[i] = 16'h0000;
  always @(posedge CLK) begin
    u_pipe[0] <= fp_exp(vexp_port_a);
    for (int i = 1; i < LAT; i++) u_pipe[i] <= u_pipe[i-1];
  end
  assign vexp_out = u_pipe[LAT-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mask(input logic [LANES-1:0] m);
`ifdef VEXP_SEQ_MASK_EN
    bus.in_mask = m;
`else
    if (m != '1) $display("note: mask ignored in this build");
`endif
  endtask

  // One full request: accept, slot-by-slot issue checks, result check, optional back-pressure, release.
  task automatic do_req(input logic [127:0] v, input logic [7:0] m, input int hold,
                        input string tag, output logic [127:0] got);
    logic [127:0] exp_v;
    int k;
    for (int i = 0; i < LANES; i++)
      exp_v[16*i +: 16] = m[i] ? fp_exp(v[16*i +: 16]) : 16'h0000;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    drive_mask(m);
    @(posedge CLK);
    #1;
    bus.in_vec = {$urandom, $urandom, $urandom, $urandom};
    drive_mask(LANES'($urandom));
    got = '0;
    for (int c = 1; c <= TOTAL; c++) begin
      @(negedge CLK);
      if (c <= LANES) begin
        check($sformatf("%s_en_%0d", tag, c), vexp_enable, m[c-1]);
        check($sformatf("%s_a_%0d", tag, c), vexp_port_a, m[c-1] ? v[16*(c-1) +: 16] : 16'h0000);
        check($sformatf("%s_busy_%0d", tag, c), {busy, bus.in_ready}, 2'b10);
      end else begin
        check($sformatf("%s_idle_unit_%0d", tag, c), {vexp_enable, vexp_port_a}, 17'd0);
      end
      if (c < TOTAL) begin
        check($sformatf("%s_ov_lo_%0d", tag, c), bus.out_valid, 0);
      end else begin
        check({tag, "_ov_hi"}, bus.out_valid, 1);
        check({tag, "_out_vec"}, bus.out_vec, exp_v);
        got = bus.out_vec;
      end
      if (c == TOTAL - 1) bus.in_valid = 1'b0;
    end
    for (int h = 1; h <= hold; h++) begin
      @(negedge CLK);
      check($sformatf("%s_hold_%0d", tag, h), {bus.out_valid, bus.in_ready}, 2'b10);
      check($sformatf("%s_hold_vec_%0d", tag, h), bus.out_vec, exp_v);
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    check({tag, "_release"}, {bus.out_valid, bus.in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] got;
    logic [7:0]   m;

    RST = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    drive_mask('1);
    @(negedge CLK);
    @(negedge CLK);
    check("rst_outs", {busy, bus.out_valid, vexp_enable, vexp_port_a}, 19'd0);
    check("rst_out_vec", bus.out_vec, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", bus.in_ready, 1);

    // All-zero vector: every lane is exp(0) = 1.0
    do_req('0, 8'hFF, 0, "zero", got);
    for (int i = 0; i < LANES; i++)
      check($sformatf("zero_lane%0d", i), got[16*i +: 16], 16'h3C00);

    // +/-1.0 in the first two lanes
    v = '0;
    v[15:0]  = 16'h3C00;
    v[31:16] = 16'hBC00;
    do_req(v, 8'hFF, 0, "pm1", got);
    check("pm1_lane0", got[15:0], 16'h4170);
    check("pm1_lane1", got[31:16], 16'h35E3);
    check("pm1_lane7", got[127:112], 16'h3C00);

    // Back-pressure: result held 20 cycles
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_fp16();
    do_req(v, 8'hFF, 20, "hold", got);

    // Reset during the 4th issue slot
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_fp16();
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge CLK);
    check("mid_en_before", vexp_enable, 1);
    RST = 1'b1;
    #1;
    check("mid_rst", {busy, vexp_enable, vexp_port_a, bus.out_valid}, 19'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_in_ready", bus.in_ready, 1);
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_fp16();
    do_req(v, 8'hFF, 0, "post_rst", got);

    // Masked lanes (all-ones in the unmasked build)
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_fp16();
    do_req(v, MASK_ON ? 8'hAA : 8'hFF, 0, "mask_aa", got);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LANES; i++) v[16*i +: 16] = rand_fp16();
      m = MASK_ON ? 8'($urandom) : 8'hFF;
      do_req(v, m, $urandom_range(0, 3), $sformatf("rnd%0d", r), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vexp_seq.md
VEXP_SEQ -- requirements
Module: vexp_seq

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning fp16 elements per vector (legal 1..16).
REQ-002 SHALL have parameter VEXP_LAT, default 3, meaning fixed vexp unit latency in cycles (legal 1..8).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request vector present.
REQ-006 SHALL have port in_ready  output  1  sequencer accepts request.
REQ-007 SHALL have port in_vec  input  LANES*16  operands; lane i at bits [16i+15:16i].
REQ-008 SHALL have port in_mask  input  LANES  lane enable, 1 = compute; present only with VEXP_SEQ_MASK_EN.
REQ-009 SHALL have port out_valid  output  1  result vector present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_vec  output  LANES*16  results, same lane packing as in_vec.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port vexp_port_a  output  16  operand to vexp unit.
REQ-014 SHALL have port vexp_enable  output  1  issue strobe to vexp unit.
REQ-015 SHALL have port vexp_out  input  16  result from vexp unit.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready at an edge SHALL latch in_vec (and in_mask) and enter ISSUE.
REQ-018 ISSUE SHALL last exactly LANES cycles, presenting lane k in its k-th cycle: vexp_enable=1, vexp_port_a=operand[k].
REQ-019 vexp_port_a SHALL be 16'h0000 whenever vexp_enable=0.
REQ-020 Operand issued in cycle t SHALL be captured from vexp_out at end of cycle t+VEXP_LAT into result lane k.
REQ-021 After the last issue the FSM SHALL enter DRAIN and remain there until the final lane is captured, then enter DONE.
REQ-022 out_valid SHALL be high exactly in DONE, first asserted LANES+VEXP_LAT+1 cycles after the accepting edge; out_vec SHALL be stable while out_valid=1.
REQ-023 out_valid&&out_ready at an edge SHALL return to IDLE; in_ready SHALL rise the following cycle (no same-cycle re-accept).
REQ-024 With out_ready held low, DONE SHALL persist indefinitely with in_ready=0.
REQ-025 in_valid/in_vec changes outside IDLE SHALL be ignored.
REQ-026 LANES=1 SHALL still traverse ISSUE (1 cycle) and DRAIN.

Reset
REQ-027 RST high SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, busy=0, vexp_enable=0, vexp_port_a=0, out_vec=0, lane counters and capture tags cleared.
REQ-028 RST asserted mid-ISSUE/DRAIN SHALL discard in-flight tags; late vexp_out values SHALL never be written.

Configuration
REQ-029 With VEXP_SEQ_MASK_EN defined, a lane with in_mask=0 SHALL keep its issue slot with vexp_enable=0 and its result SHALL be 16'h0000; latency unchanged.
REQ-030 Without VEXP_SEQ_MASK_EN, in_mask SHALL not exist and every lane SHALL be issued.

Structure
REQ-031 vector_pkg SHALL hold the fp16 typedef, the vexp_seq_state_t enum, and VEXP_LAT default constant.
REQ-032 Capture tags SHALL live in sub-module vexp_tag_pipe: VEXP_LAT-deep shift register of {valid, lane index} with synchronous flush.

Verification
REQ-033 LANES=8, VEXP_LAT=3, in_vec all 16'h0000, out_ready=1 -> out_valid exactly 12 cycles after accept, out_vec all 16'h3C00.
REQ-034 in_vec lanes {16'h3C00, 16'hBC00, 0...} -> lane0=16'h4170, lane1=16'h35E3 (model exp), others 16'h3C00.
REQ-035 out_ready low 20 cycles after out_valid -> out_vec stable, in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-036 RST pulsed in ISSUE cycle 4 -> busy=0 and vexp_enable=0 immediately; next request returns correct results with no stale lanes.
REQ-037 With VEXP_SEQ_MASK_EN, in_mask=8'b1010_1010 -> vexp_enable low in even slots, even lanes 16'h0000, latency still 12.
